// File: rtl/led_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// led_accumulator_pkg
// Shared constants and helpers for the LED accumulator slice.
//   SYNC_STAGES   : depth of every input synchroniser chain
//   counter_width : bits needed to hold the values 0..max_count
// -----------------------------------------------------------------------------
package led_accumulator_pkg;

  localparam int SYNC_STAGES = 2;

  // ceil(log2(max_count+1)), never less than 1.
  function automatic int counter_width(input int max_count);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(max_count + 1)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/led_accumulator_if.sv
// -----------------------------------------------------------------------------
// led_accumulator_if
// Board-side signal bundle between the switch pins and the LED pins.
//   i_Operand : raw operand switches (WIDTH bits, MSB = WIDTH-1)
//   i_Add_Sw  : raw add push-switch, 1 = pressed
//   i_Clr_Sw  : raw clear push-switch, 1 = pressed
//   o_LED     : accumulator value
//   o_Carry   : sticky overflow flag
// Modports:
//   master : drives the switches, observes the LEDs (board / testbench)
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface led_accumulator_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] i_Operand;
  logic             i_Add_Sw;
  logic             i_Clr_Sw;
  logic [WIDTH-1:0] o_LED;
  logic             o_Carry;

  modport master (
    output i_Operand,
    output i_Add_Sw,
    output i_Clr_Sw,
    input  o_LED,
    input  o_Carry
  );

  modport slave (
    input  i_Operand,
    input  i_Add_Sw,
    input  i_Clr_Sw,
    output o_LED,
    output o_Carry
  );

endinterface

// File: rtl/led_accumulator_switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Synchronises one raw push-switch, debounces it and emits a one-cycle pulse
// on each accepted press.
//   i_Clk   : clock
//   i_Rst   : synchronous, active-high reset
//   i_Sw    : raw switch level (asynchronous to i_Clk)
//   o_Level : debounced level
//   o_Press : one-cycle pulse on each 0->1 transition of o_Level
// A new level is accepted once the synchronised sample has differed from the
// current level for DEBOUNCE_CYCLES consecutive clocks; any agreeing sample
// before that restarts the count.
// -----------------------------------------------------------------------------
module switch_debounce
  import led_accumulator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Sw,
  output logic o_Level,
  output logic o_Press
);

  localparam int              CNT_W    = counter_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   level_prev_q;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // NOTE: every flop in a clocked block uses <= so all of them see the
  // pre-edge values of each other, independent of statement order.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], i_Sw};
      level_prev_q <= level_q;
      if (sample == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // DEBOUNCE_CYCLES disagreeing samples in a row: accept the new level.
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_Level = level_q;
  // Built from two flops only, so no input reaches it combinationally.
  assign o_Press = level_q & ~level_prev_q;

endmodule

// File: rtl/led_accumulator.sv
// -----------------------------------------------------------------------------
// led_accumulator
// Debounced switch-driven accumulator for the iCE40 board. Each accepted press
// of the add switch adds the (synchronised) operand switches into a WIDTH-bit
// accumulator; a press of the clear switch zeroes it. The value drives the
// LEDs, overflow sets a sticky carry.
//   i_Clk  : clock, sole domain
//   i_Rst  : synchronous, active-high reset
//   sw     : led_accumulator_if.slave (i_Operand, i_Add_Sw, i_Clr_Sw in;
//            o_LED, o_Carry out, both registered)
// Build option:
//   LED_ACCUMULATOR_SATURATE_EN : when defined, an overflowing add pins the
//   accumulator at all ones instead of wrapping. o_Carry is unaffected.
// -----------------------------------------------------------------------------
module led_accumulator
  import led_accumulator_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  led_accumulator_if.slave sw
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] op_sync_q;
  logic [WIDTH-1:0]                  acc_q;
  logic                              carry_q;
  logic                              add_press;
  logic                              clr_press;
  // The datapath only needs the press pulses, not the debounced levels.
  logic [1:0]                        unused_levels;

  switch_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_add_debounce (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Sw    (sw.i_Add_Sw),
    .o_Level (unused_levels[0]),
    .o_Press (add_press)
  );

  switch_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_clr_debounce (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Sw    (sw.i_Clr_Sw),
    .o_Level (unused_levels[1]),
    .o_Press (clr_press)
  );

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_next;
  logic             carry_next;

  // NOTE: every variable gets a default before any branch so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_next   = acc_q;
    carry_next = carry_q;
    sum        = {1'b0, acc_q} + {1'b0, op_sync_q[SYNC_STAGES-1]};
    if (clr_press) begin
      // Clear beats a simultaneous add; the add is simply dropped.
      acc_next   = '0;
      carry_next = 1'b0;
    end else if (add_press) begin
`ifdef LED_ACCUMULATOR_SATURATE_EN
      acc_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
      acc_next = sum[WIDTH-1:0];
`endif
      carry_next = carry_q | sum[WIDTH];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      op_sync_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      op_sync_q <= {op_sync_q[SYNC_STAGES-2:0], sw.i_Operand};
      acc_q     <= acc_next;
      carry_q   <= carry_next;
    end
  end

  assign sw.o_LED   = acc_q;
  assign sw.o_Carry = carry_q;

endmodule
